// File: rtl/rev_counter_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rev_counter_ctrl_pkg
//  Description : Shared encodings for the reversible counter controller.
//                Holds the FSM state codes, the terminal-count mode codes
//                and a helper that classifies a latched mode.
//  Revision    : 1.0  initial release
// ============================================================================
package rev_counter_ctrl_pkg;

    // FSM state encodings
    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_RUN   = 2'd1;
    localparam logic [1:0] c_ST_PAUSE = 2'd2;
    localparam logic [1:0] c_ST_DONE  = 2'd3;

    // Terminal-count behaviour encodings
    localparam logic [1:0] c_MODE_ONESHOT  = 2'b00;
    localparam logic [1:0] c_MODE_RELOAD   = 2'b01;
    localparam logic [1:0] c_MODE_PINGPONG = 2'b10;

    // The unused code 2'b11 behaves as one-shot, so one-shot is simply
    // "neither reload nor ping-pong".
    function automatic logic is_oneshot(input logic [1:0] m);
        return !((m == c_MODE_RELOAD) || (m == c_MODE_PINGPONG));
    endfunction

endpackage
`default_nettype wire

// File: rtl/rev_counter_ctrl_tick.sv
`default_nettype none
// ============================================================================
//  Module      : rev_tick_gen
//  Description : Prescale divider. While enabled, asserts tick once every
//                div+1 enabled cycles. The count freezes while disabled so a
//                paused run resumes mid-period.
//  Ports       : clk, rst (async, active-high)
//                en   - count enable (controller in RUN and not stopping)
//                clr  - synchronous clear (counter load)
//                div  - divide value, tick every div+1 enabled cycles
//                tick - combinational step strobe
//  Revision    : 1.0  initial release
// ============================================================================
module rev_tick_gen #(
    parameter int PRESCALE_W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  clr,
    input  logic [PRESCALE_W-1:0] div,
    output logic                  tick
);

    localparam logic [PRESCALE_W-1:0] c_ONE = {{(PRESCALE_W-1){1'b0}}, 1'b1};

    logic [PRESCALE_W-1:0] r_pc;

    assign tick = en && (r_pc == div);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc <= '0;
        end else if (clr) begin
            r_pc <= '0;
        end else if (en) begin
            if (tick) begin
                r_pc <= '0;
            end else begin
                r_pc <= r_pc + c_ONE;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/rev_counter_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : rev_counter_ctrl
//  Description : Sequencing controller for a reversible WIDTH-bit counter.
//                Loads a start value, steps up/down at a prescaled rate and
//                on terminal count stops, reloads or reverses direction.
//  Ports       : clk, rst (async, active-high)
//                start, stop          - commands (stop wins when both high)
//                dir, mode, load_val,
//                limit, prescale      - configuration, sampled on load
//                cnt, dir_q           - registered count and direction
//                rc                   - one-cycle terminal-count pulse
//                busy, done           - state flags (RUN/PAUSE, DONE)
//  Revision    : 1.0  initial release
// ============================================================================
module rev_counter_ctrl
    import rev_counter_ctrl_pkg::*;
#(
    parameter int WIDTH      = 16,
    parameter int PRESCALE_W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  dir,
    input  logic [1:0]            mode,
    input  logic [WIDTH-1:0]      load_val,
    input  logic [WIDTH-1:0]      limit,
    input  logic [PRESCALE_W-1:0] prescale,
    output logic [WIDTH-1:0]      cnt,
    output logic                  dir_q,
    output logic                  rc,
    output logic                  busy,
    output logic                  done
);

    localparam logic [WIDTH-1:0] c_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [1:0]            r_state;
    logic [1:0]            w_state_nxt;
    logic [WIDTH-1:0]      r_cnt;
    logic                  r_dir;
    logic                  r_rc;
    logic [1:0]            r_mode;
    logic [WIDTH-1:0]      r_limit;
    logic [WIDTH-1:0]      r_load;
    logic [PRESCALE_W-1:0] r_prescale;

    logic w_load;
    logic w_run_en;
    logic w_tick;
    logic w_tc;

    // A load is only accepted from an idle or finished controller; stop
    // always takes priority over start.
    assign w_load   = start && !stop && ((r_state == c_ST_IDLE) || (r_state == c_ST_DONE));
    // A stop seen in RUN freezes the count at that very edge.
    assign w_run_en = (r_state == c_ST_RUN) && !stop;
    assign w_tc     = r_dir ? (r_cnt == r_limit) : (r_cnt == '0);

    rev_tick_gen #(
        .PRESCALE_W (PRESCALE_W)
    ) u_tick (
        .clk  (clk),
        .rst  (rst),
        .en   (w_run_en),
        .clr  (w_load),
        .div  (r_prescale),
        .tick (w_tick)
    );

    // ---------------- FSM ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE, c_ST_DONE: begin
                if (w_load) w_state_nxt = c_ST_RUN;
            end
            c_ST_RUN: begin
                if (stop) begin
                    w_state_nxt = c_ST_PAUSE;
                end else if (w_tick && w_tc && is_oneshot(r_mode)) begin
                    w_state_nxt = c_ST_DONE;
                end
            end
            c_ST_PAUSE: begin
                if (stop) begin
                    w_state_nxt = c_ST_IDLE;
                end else if (start) begin
                    w_state_nxt = c_ST_RUN;
                end
            end
            default: w_state_nxt = c_ST_IDLE;
        endcase
    end

    // ---------------- Count datapath ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt      <= '0;
            r_dir      <= 1'b0;
            r_rc       <= 1'b0;
            r_mode     <= '0;
            r_limit    <= '0;
            r_load     <= '0;
            r_prescale <= '0;
        end else begin
            r_rc <= 1'b0;
            if (w_load) begin
                r_cnt      <= load_val;
                r_dir      <= dir;
                r_mode     <= mode;
                r_limit    <= limit;
                r_load     <= load_val;
                r_prescale <= prescale;
            end else if (w_tick) begin
                if (w_tc) begin
                    r_rc <= 1'b1;
                    // One-shot holds the count; the FSM moves to DONE.
                    if (r_mode == c_MODE_RELOAD) begin
                        r_cnt <= r_load;
                    end else if (r_mode == c_MODE_PINGPONG) begin
                        r_dir <= ~r_dir;
                    end
                end else if (r_dir) begin
                    r_cnt <= r_cnt + c_ONE;
                end else begin
                    r_cnt <= r_cnt - c_ONE;
                end
            end
        end
    end

    assign cnt   = r_cnt;
    assign dir_q = r_dir;
    assign rc    = r_rc;
    assign busy  = (r_state == c_ST_RUN) || (r_state == c_ST_PAUSE);
    assign done  = (r_state == c_ST_DONE);

endmodule
`default_nettype wire

// File: tb/tb_rev_counter_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rev_counter_ctrl
//  Description : Self-checking bench for rev_counter_ctrl. A table of
//                per-cycle vectors covers one-shot and ping-pong runs plus
//                pause/abort; hand-written sequences cover prescaled
//                auto-reload, wrap-around, pause/resume and async reset.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_rev_counter_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        dir = 1'b0;
    logic [1:0]  mode = 2'b00;
    logic [15:0] load_val = '0;
    logic [15:0] limit = '0;
    logic [7:0]  prescale = '0;
    logic [15:0] cnt;
    logic        dir_q;
    logic        rc;
    logic        busy;
    logic        done;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rev_counter_ctrl #(
        .WIDTH      (16),
        .PRESCALE_W (8)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .stop     (stop),
        .dir      (dir),
        .mode     (mode),
        .load_val (load_val),
        .limit    (limit),
        .prescale (prescale),
        .cnt      (cnt),
        .dir_q    (dir_q),
        .rc       (rc),
        .busy     (busy),
        .done     (done)
    );

    typedef struct {
        logic        start;
        logic        stop;
        logic        dir;
        logic [1:0]  mode;
        logic [15:0] load_val;
        logic [15:0] limit;
        logic [7:0]  prescale;
        logic [15:0] e_cnt;
        logic        e_dir;
        logic        e_rc;
        logic        e_busy;
        logic        e_done;
    } vec_t;

    vec_t tbl[16];

    function automatic vec_t mkv(input logic s, input logic p, input logic d,
                                 input logic [1:0] m, input logic [15:0] lv,
                                 input logic [15:0] lim, input logic [7:0] ps,
                                 input logic [15:0] ec, input logic ed,
                                 input logic er, input logic eb, input logic edn);
        vec_t t;
        t.start = s;  t.stop = p;  t.dir = d;  t.mode = m;
        t.load_val = lv;  t.limit = lim;  t.prescale = ps;
        t.e_cnt = ec;  t.e_dir = ed;  t.e_rc = er;  t.e_busy = eb;  t.e_done = edn;
        return t;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_all(input string nm, input logic [15:0] ec, input logic ed,
                           input logic er, input logic eb, input logic edn);
        chk({nm, ".cnt"},   {16'd0, cnt},   {16'd0, ec});
        chk({nm, ".dir_q"}, {31'd0, dir_q}, {31'd0, ed});
        chk({nm, ".rc"},    {31'd0, rc},    {31'd0, er});
        chk({nm, ".busy"},  {31'd0, busy},  {31'd0, eb});
        chk({nm, ".done"},  {31'd0, done},  {31'd0, edn});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic d, input logic [1:0] m, input logic [15:0] lv,
                        input logic [15:0] lim, input logic [7:0] ps);
        dir = d; mode = m; load_val = lv; limit = lim; prescale = ps;
        start = 1'b1; stop = 1'b0;
        step();
        start = 1'b0;
    endtask

    initial begin
        logic [15:0] wexp[5];
        // ---------------- reset ----------------
        step();
        step();
        chk_all("reset", 16'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;

        // ---------------- table: one-shot up, ping-pong, pause/abort ----------------
        tbl[0]  = mkv(1,0,1,2'b00,16'd3,16'd6,8'd0, 16'd3,1,0,1,0);
        tbl[1]  = mkv(0,0,1,2'b00,16'd3,16'd6,8'd0, 16'd4,1,0,1,0);
        tbl[2]  = mkv(0,0,1,2'b00,16'd3,16'd6,8'd0, 16'd5,1,0,1,0);
        tbl[3]  = mkv(0,0,1,2'b00,16'd3,16'd6,8'd0, 16'd6,1,0,1,0);
        tbl[4]  = mkv(0,0,1,2'b00,16'd3,16'd6,8'd0, 16'd6,1,1,0,1);
        tbl[5]  = mkv(0,0,1,2'b00,16'd3,16'd6,8'd0, 16'd6,1,0,0,1);
        tbl[6]  = mkv(1,0,1,2'b10,16'd0,16'd2,8'd0, 16'd0,1,0,1,0);
        tbl[7]  = mkv(0,0,1,2'b10,16'd0,16'd2,8'd0, 16'd1,1,0,1,0);
        tbl[8]  = mkv(0,0,1,2'b10,16'd0,16'd2,8'd0, 16'd2,1,0,1,0);
        tbl[9]  = mkv(0,0,1,2'b10,16'd0,16'd2,8'd0, 16'd2,0,1,1,0);
        tbl[10] = mkv(0,0,1,2'b10,16'd0,16'd2,8'd0, 16'd1,0,0,1,0);
        tbl[11] = mkv(0,0,1,2'b10,16'd0,16'd2,8'd0, 16'd0,0,0,1,0);
        tbl[12] = mkv(0,0,1,2'b10,16'd0,16'd2,8'd0, 16'd0,1,1,1,0);
        tbl[13] = mkv(0,0,1,2'b10,16'd0,16'd2,8'd0, 16'd1,1,0,1,0);
        tbl[14] = mkv(0,1,1,2'b10,16'd0,16'd2,8'd0, 16'd1,1,0,1,0);
        tbl[15] = mkv(0,1,1,2'b10,16'd0,16'd2,8'd0, 16'd1,1,0,0,0);

        for (int i = 0; i < 16; i++) begin
            start = tbl[i].start;  stop = tbl[i].stop;  dir = tbl[i].dir;
            mode = tbl[i].mode;  load_val = tbl[i].load_val;
            limit = tbl[i].limit;  prescale = tbl[i].prescale;
            step();
            chk_all($sformatf("vec%0d", i), tbl[i].e_cnt, tbl[i].e_dir,
                    tbl[i].e_rc, tbl[i].e_busy, tbl[i].e_done);
        end
        stop = 1'b0;

        // ---------------- auto-reload down, prescale 2 ----------------
        load(1'b0, 2'b01, 16'd2, 16'd9, 8'd2);
        chk_all("reload.k0", 16'd2, 1'b0, 1'b0, 1'b1, 1'b0);
        for (int k = 1; k <= 27; k++) begin
            int m;
            logic [15:0] ec;
            step();
            m  = k % 9;
            ec = (m < 3) ? 16'd2 : ((m < 6) ? 16'd1 : 16'd0);
            chk_all($sformatf("reload.k%0d", k), ec, 1'b0, (m == 0), 1'b1, 1'b0);
        end
        stop = 1'b1;
        step();
        step();
        stop = 1'b0;
        chk_all("reload.abort", 16'd2, 1'b0, 1'b0, 1'b0, 1'b0);

        // ---------------- wrap-around up, one-shot ----------------
        wexp[0] = 16'hFFFE; wexp[1] = 16'hFFFF; wexp[2] = 16'h0000;
        wexp[3] = 16'h0001; wexp[4] = 16'h0001;
        load(1'b1, 2'b00, 16'hFFFE, 16'd1, 8'd0);
        for (int k = 0; k < 5; k++) begin
            if (k > 0) step();
            chk_all($sformatf("wrap.e%0d", k), wexp[k], 1'b1, (k == 4), (k != 4), (k == 4));
        end

        // ---------------- pause / resume ----------------
        load(1'b1, 2'b00, 16'd0, 16'd20, 8'd0);
        for (int k = 1; k <= 5; k++) step();
        chk_all("pause.run5", 16'd5, 1'b1, 1'b0, 1'b1, 1'b0);
        stop = 1'b1;
        step();
        stop = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            chk_all($sformatf("pause.hold%0d", k), 16'd5, 1'b1, 1'b0, 1'b1, 1'b0);
        end
        start = 1'b1;
        step();
        start = 1'b0;
        chk_all("pause.resume_edge", 16'd5, 1'b1, 1'b0, 1'b1, 1'b0);
        step();
        chk_all("pause.resume6", 16'd6, 1'b1, 1'b0, 1'b1, 1'b0);
        start = 1'b1; stop = 1'b1;
        step();
        start = 1'b0; stop = 1'b0;
        step();
        chk_all("pause.startstop", 16'd6, 1'b1, 1'b0, 1'b1, 1'b0);

        // ---------------- async reset mid-RUN ----------------
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        chk_all("areset.before", 16'd8, 1'b1, 1'b0, 1'b1, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        chk_all("areset.async", 16'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        rst = 1'b0;
        step();
        step();
        chk_all("areset.idle", 16'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        load(1'b1, 2'b00, 16'd7, 16'd9, 8'd0);
        chk_all("areset.reload", 16'd7, 1'b1, 1'b0, 1'b1, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/rev_counter_ctrl.md
Name: rev_counter_ctrl

Overview:
Sequencing controller for a reversible (up/down) WIDTH-bit counter datapath. It loads a start value, steps the count up or down at a prescaled rate, and detects terminal count. At terminal count it stops (one-shot), reloads (auto-reload) or reverses direction (ping-pong). It sits between a command source (buttons, switches, host FSM) and the display/consumer of the count.

Parameters:
WIDTH, 16, counter width in bits
PRESCALE_W, 8, width of prescale divider field

Ports:
clk  input  1  system clock, all state updates on posedge
rst  input  1  asynchronous, active-high reset
start  input  1  command: load/begin (IDLE/DONE) or resume (PAUSE)
stop  input  1  command: pause (RUN) or abort (PAUSE)
dir  input  1  initial direction, 1=up, 0=down; sampled on load
mode  input  2  00 one-shot, 01 auto-reload, 10 ping-pong, 11 treated as one-shot; sampled on load
load_val  input  WIDTH  start/reload value; sampled on load
limit  input  WIDTH  up-count terminal value; sampled on load
prescale  input  PRESCALE_W  step every prescale+1 RUN cycles; sampled on load
cnt  output  WIDTH  current count (registered)
dir_q  output  1  current direction (registered)
rc  output  1  one-cycle terminal-count pulse (registered)
busy  output  1  high in RUN or PAUSE
done  output  1  high in DONE

Behaviour:
- Reset (async, rst=1): state IDLE; cnt=0, dir_q=0, rc=0, prescale counter pc=0, all latched config regs=0; busy=0, done=0.
- States: IDLE, RUN, PAUSE, DONE. busy/done decoded combinationally from state.
- Load: start=1 && stop=0 in IDLE or DONE -> at that edge cnt<=load_val, dir_q<=dir, latch mode/limit/load_val/prescale, pc<=0, state RUN.
- start in RUN ignored. start=1 with stop=1 in any state: stop wins.
- RUN: tick = (pc == prescale_q); on tick pc<=0, else pc<=pc+1. With prescale 0, tick every RUN cycle; first step at the edge after load.
- Terminal: tc = dir_q ? (cnt == limit_q) : (cnt == 0). Evaluated only on tick.
- Tick with tc=0: cnt <= cnt+1 (up) or cnt-1 (down), modulo 2^WIDTH. Wrap FFFF->0000 up and 0000->FFFF down is legal, and counting continues toward the terminal value.
- Tick with tc=1: rc<=1 for exactly one cycle, plus:
  - one-shot: cnt holds, state DONE.
  - auto-reload: cnt<=load_q, stay RUN.
  - ping-pong: dir_q<=~dir_q, cnt holds this tick, stay RUN.
- rc=0 in every other cycle.
- stop in RUN -> PAUSE: cnt, dir_q, pc frozen.
- start in PAUSE -> RUN: resume, no reload, pc continues.
- stop in PAUSE -> IDLE: cnt holds its value.
- DONE: cnt holds; only a load (start) leaves DONE.
- rst asserted mid-operation: immediate return to reset values regardless of state or pending tick.

Decomposition:
- Shared package: state encodings (IDLE, RUN, PAUSE, DONE) and mode encodings (MODE_ONESHOT, MODE_RELOAD, MODE_PINGPONG).
- One natural sub-module: rev_tick_gen, the prescale counter. Inputs clk, rst, en (RUN), clr (load), div; output tick.
- FSM and count datapath stay in rev_counter_ctrl.

Test Plan:
- One-shot up: load_val=3, limit=6, prescale=0, dir=1, mode=00, start pulse at edge0 -> cnt 3,4,5,6 at edges 0..3; at edge4 rc=1 for one cycle, done=1, cnt stays 6.
- Auto-reload down: load_val=2, prescale=2, dir=0, mode=01 -> each of 2,1,0 held 3 cycles, then reload to 2; rc pulses every 9 cycles; busy stays 1.
- Ping-pong: load_val=0, limit=2, dir=1, prescale=0, mode=10 -> cnt 0,1,2,2,1,0,0,1...; rc and dir_q toggle at each repeated value.
- Wrap: load_val=16'hFFFE, limit=1, up, one-shot -> FFFE, FFFF, 0000, 0001, then rc and DONE.
- Pause/resume: stop mid-run with cnt=5 -> cnt holds 5 for N cycles in PAUSE; start -> count resumes 6 with no reload. start+stop together in RUN -> PAUSE.
- Async reset mid-RUN: assert rst between edges -> cnt=0, rc=0, busy=0 immediately, without waiting for clk; after release, start is needed to run again.
